// File: rtl/priv_1_7_csr_host_master.sv
// External-host initiator for the machine-mode CSR file: takes one command at a time,
// freezes the pipeline, owns the shared CSR port for a single cycle and returns old data.
module priv_1_7_csr_host_master #(
  parameter int MAX_WAIT = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic        host_stall_req,
  input  logic        pipe_stalled,
  output logic        host_grant,
  output logic [11:0] csr_addr,
  output logic        csr_swap,
  output logic        csr_set,
  output logic        csr_clr,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata,
  input  logic        csr_invalid
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WAIT   = 2'b01,
    ACCESS = 2'b10,
    RESP   = 2'b11
  } state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_SWAP  = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_INVALID = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_RO      = 2'b11;

  localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

  state_t      state_r, state_s;
  logic [1:0]  op_r;
  logic [11:0] addr_r;
  logic [31:0] wdata_r;
  logic [7:0]  wait_cnt_r;

  logic        req_ready_r, rsp_valid_r, stall_r, grant_r;
  logic        swap_r, set_r, clr_r;
  logic [11:0] csr_addr_r;
  logic [31:0] csr_wdata_r, rsp_rdata_r;
  logic [1:0]  rsp_err_r;

  logic        accept_s, ro_reject_s, access_s;
  logic        swap_s, set_s, clr_s;
  logic [11:0] csr_addr_s;
  logic [31:0] csr_wdata_s;

  // Next-state decode and next-cycle port values for the registered outputs.
  always_comb begin
    state_s     = state_r;
    accept_s    = (state_r == IDLE) && req_valid;
    ro_reject_s = (req_addr[11:10] == 2'b11) && (req_op != OP_READ);
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (ro_reject_s) begin
            state_s = RESP;
          end else begin
            state_s = WAIT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (pipe_stalled) begin
          state_s = ACCESS;
        end else if (wait_cnt_r == LAST_WAIT) begin
          state_s = RESP;
        end else begin
          state_s = WAIT;
        end
      end
      ACCESS: state_s = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase

    // A read is issued as a set with zero mask so the file still judges the address.
    access_s    = (state_s == ACCESS);
    swap_s      = access_s && (op_r == OP_SWAP);
    set_s       = access_s && ((op_r == OP_SET) || (op_r == OP_READ));
    clr_s       = access_s && (op_r == OP_CLEAR);
    if (access_s) begin
      csr_addr_s = addr_r;
    end else begin
      csr_addr_s = 12'h000;
    end
    if (access_s && (op_r != OP_READ)) begin
      csr_wdata_s = wdata_r;
    end else begin
      csr_wdata_s = 32'h0000_0000;
    end
  end

  // State, command latch, wait counter, response and registered port drivers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r     <= IDLE;
      op_r        <= 2'b00;
      addr_r      <= 12'h000;
      wdata_r     <= 32'h0000_0000;
      wait_cnt_r  <= 8'd0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= ERR_OK;
      stall_r     <= 1'b0;
      grant_r     <= 1'b0;
      swap_r      <= 1'b0;
      set_r       <= 1'b0;
      clr_r       <= 1'b0;
      csr_addr_r  <= 12'h000;
      csr_wdata_r <= 32'h0000_0000;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        op_r    <= req_op;
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
      end
      if (state_r == IDLE) begin
        wait_cnt_r <= 8'd0;
      end else if ((state_r == WAIT) && !pipe_stalled && (wait_cnt_r != 8'hFF)) begin
        wait_cnt_r <= wait_cnt_r + 8'd1;
      end
      if ((state_r == IDLE) && (state_s == RESP)) begin
        rsp_rdata_r <= 32'h0000_0000;
        rsp_err_r   <= ERR_RO;
      end else if ((state_r == WAIT) && (state_s == RESP)) begin
        rsp_rdata_r <= 32'h0000_0000;
        rsp_err_r   <= ERR_TIMEOUT;
      end else if (state_r == ACCESS) begin
        rsp_rdata_r <= csr_invalid ? 32'h0000_0000 : csr_rdata;
        rsp_err_r   <= csr_invalid ? ERR_INVALID : ERR_OK;
      end
      req_ready_r <= (state_s == IDLE);
      rsp_valid_r <= (state_s == RESP);
      stall_r     <= (state_s == WAIT) || (state_s == ACCESS);
      grant_r     <= access_s;
      swap_r      <= swap_s;
      set_r       <= set_s;
      clr_r       <= clr_s;
      csr_addr_r  <= csr_addr_s;
      csr_wdata_r <= csr_wdata_s;
    end
  end

  assign req_ready      = req_ready_r;
  assign rsp_valid      = rsp_valid_r;
  assign rsp_rdata      = rsp_rdata_r;
  assign rsp_err        = rsp_err_r;
  assign host_stall_req = stall_r;
  assign host_grant     = grant_r;
  assign csr_addr       = csr_addr_r;
  assign csr_swap       = swap_r;
  assign csr_set        = set_r;
  assign csr_clr        = clr_r;
  assign csr_wdata      = csr_wdata_r;

endmodule

// File: tb/tb_priv_1_7_csr_host_master.sv
// Directed bench for priv_1_7_csr_host_master against a two-register CSR file model
// (MSCRATCH read/write at 0x340, MHARTID read-only at 0xF10, everything else unmapped).
module tb_priv_1_7_csr_host_master;
  localparam int MW = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0]  req_op, rsp_err;
  logic [11:0] req_addr, csr_addr;
  logic [31:0] req_wdata, rsp_rdata, csr_wdata, csr_rdata;
  logic        host_stall_req, pipe_stalled, host_grant;
  logic        csr_swap, csr_set, csr_clr, csr_invalid;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [31:0] mscratch;
  logic        preload_en;
  logic [31:0] preload_val;

  priv_1_7_csr_host_master #(.MAX_WAIT(MW)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .host_stall_req(host_stall_req), .pipe_stalled(pipe_stalled), .host_grant(host_grant),
    .csr_addr(csr_addr), .csr_swap(csr_swap), .csr_set(csr_set), .csr_clr(csr_clr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_invalid(csr_invalid)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // CSR file model: unmapped reads return junk so the zeroing of rdata is visible.
  assign csr_rdata   = (csr_addr == 12'h340) ? mscratch :
                       (csr_addr == 12'hF10) ? 32'h0000_0007 : 32'hBAD0_BAD0;
  assign csr_invalid = !((csr_addr == 12'h340) || (csr_addr == 12'hF10));

  always @(posedge CLK) begin
    if (preload_en) mscratch <= preload_val;
    else if (csr_addr == 12'h340) begin
      if (csr_swap)     mscratch <= csr_wdata;
      else if (csr_set) mscratch <= mscratch | csr_wdata;
      else if (csr_clr) mscratch <= mscratch & ~csr_wdata;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Issues one command; pipe_stalled goes high from WAIT cycle st_at onward.
  task automatic do_cmd(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                        input int st_at, output logic [31:0] rd, output logic [1:0] er,
                        output int lat, output int grants, output int stalls);
    req_op = op; req_addr = addr; req_wdata = wd; req_valid = 1'b1; pipe_stalled = 1'b0;
    step();
    req_valid = 1'b0; lat = 1; grants = 0; stalls = 0;
    while (rsp_valid !== 1'b1 && lat < 64) begin
      pipe_stalled = (lat >= st_at);
      if (host_grant === 1'b1) grants++;
      if (host_stall_req === 1'b1) stalls++;
      step();
      lat++;
    end
    if (host_grant === 1'b1) grants++;
    if (host_stall_req === 1'b1) stalls++;
    vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, want 1", rsp_valid, lat); end
    pipe_stalled = 1'b0;
    rd = rsp_rdata; er = rsp_err;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b0; preload_en = 1'b1; preload_val = 32'hDEAD_BEEF;
    step(); step();
    preload_en = 1'b0;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    vectors++; if ({rsp_valid, rsp_err, rsp_rdata} !== 35'h0) begin miscompares++; $display("FAIL reset_rsp: got %b/%b/%h want 0/00/0", rsp_valid, rsp_err, rsp_rdata); end
    vectors++; if ({host_stall_req, host_grant, csr_swap, csr_set, csr_clr} !== 5'b0) begin miscompares++; $display("FAIL reset_ctrl: got %b want 00000", {host_stall_req, host_grant, csr_swap, csr_set, csr_clr}); end
    vectors++; if ({csr_addr, csr_wdata} !== 44'h0) begin miscompares++; $display("FAIL reset_port: got %h/%h want 0/0", csr_addr, csr_wdata); end
    nRST = 1'b1;
    step();
  endtask

  task automatic test_read();
    pipe_stalled = 1'b1;
    req_op = 2'b00; req_addr = 12'h340; req_wdata = 32'hFFFF_FFFF; req_valid = 1'b1;
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL read_ready: got %b want 1", req_ready); end
    step();
    req_valid = 1'b0;
    vectors++; if ({host_stall_req, host_grant, rsp_valid} !== 3'b100) begin miscompares++; $display("FAIL read_wait: stall/grant/valid %b want 100", {host_stall_req, host_grant, rsp_valid}); end
    step();
    vectors++; if ({host_grant, csr_set, csr_swap, csr_clr} !== 4'b1100) begin miscompares++; $display("FAIL read_access_strobes: got %b want 1100", {host_grant, csr_set, csr_swap, csr_clr}); end
    vectors++; if ({csr_addr, csr_wdata} !== {12'h340, 32'h0}) begin miscompares++; $display("FAIL read_access_port: got %h/%h want 340/0", csr_addr, csr_wdata); end
    step();
    vectors++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 2'b00, 32'hDEAD_BEEF}) begin miscompares++; $display("FAIL read_rsp: got %b/%b/%h want 1/00/deadbeef", rsp_valid, rsp_err, rsp_rdata); end
    vectors++; if ({host_stall_req, host_grant, csr_set} !== 3'b000) begin miscompares++; $display("FAIL read_resp_release: got %b want 000", {host_stall_req, host_grant, csr_set}); end
    pipe_stalled = 1'b0; rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    vectors++; if ({rsp_valid, req_ready} !== 2'b01) begin miscompares++; $display("FAIL read_done: valid/ready %b want 01", {rsp_valid, req_ready}); end
    vectors++; if (mscratch !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL read_unmodified: mscratch %h want deadbeef", mscratch); end
  endtask

  task automatic test_rmw();
    logic [31:0] rd; logic [1:0] er; int lat, g, s;
    do_cmd(2'b01, 12'h340, 32'h1234_5678, 1, rd, er, lat, g, s);
    vectors++; if ({er, rd} !== {2'b00, 32'hDEAD_BEEF} || lat != 3) begin miscompares++; $display("FAIL swap: got %b/%h lat %0d want 00/deadbeef lat 3", er, rd, lat); end
    do_cmd(2'b10, 12'h340, 32'h0000_000F, 1, rd, er, lat, g, s);
    vectors++; if ({er, rd} !== {2'b00, 32'h1234_5678}) begin miscompares++; $display("FAIL set: got %b/%h want 00/12345678", er, rd); end
    do_cmd(2'b11, 12'h340, 32'h0000_0001, 1, rd, er, lat, g, s);
    vectors++; if ({er, rd} !== {2'b00, 32'h1234_567F}) begin miscompares++; $display("FAIL clear: got %b/%h want 00/1234567f", er, rd); end
    vectors++; if (mscratch !== 32'h1234_567E) begin miscompares++; $display("FAIL rmw_final: mscratch %h want 1234567e", mscratch); end
  endtask

  task automatic test_invalid();
    logic [31:0] rd; logic [1:0] er; int lat, g, s;
    do_cmd(2'b00, 12'h7FF, 32'h0, 1, rd, er, lat, g, s);
    vectors++; if ({er, rd} !== {2'b01, 32'h0}) begin miscompares++; $display("FAIL invalid_rsp: got %b/%h want 01/0", er, rd); end
    vectors++; if (g != 1) begin miscompares++; $display("FAIL invalid_grants: got %0d want 1", g); end
  endtask

  task automatic test_readonly();
    logic [31:0] rd; logic [1:0] er; int lat, g, s;
    do_cmd(2'b01, 12'hF10, 32'hFFFF_FFFF, 1, rd, er, lat, g, s);
    vectors++; if ({er, rd} !== {2'b11, 32'h0} || lat != 1) begin miscompares++; $display("FAIL ro_reject: got %b/%h lat %0d want 11/0 lat 1", er, rd, lat); end
    vectors++; if (g != 0 || s != 0) begin miscompares++; $display("FAIL ro_port_untouched: grants %0d stalls %0d want 0 0", g, s); end
    do_cmd(2'b00, 12'hF10, 32'h0, 1, rd, er, lat, g, s);
    vectors++; if ({er, rd} !== {2'b00, 32'h7} || lat != 3) begin miscompares++; $display("FAIL ro_read: got %b/%h lat %0d want 00/7 lat 3", er, rd, lat); end
  endtask

  task automatic test_timeout();
    logic [31:0] rd; logic [1:0] er; int lat, g, s;
    do_cmd(2'b00, 12'h340, 32'h0, 1000, rd, er, lat, g, s);
    vectors++; if ({er, rd} !== {2'b10, 32'h0} || lat != 5) begin miscompares++; $display("FAIL timeout_rsp: got %b/%h lat %0d want 10/0 lat 5", er, rd, lat); end
    vectors++; if (s != 4 || g != 0) begin miscompares++; $display("FAIL timeout_stall: stalls %0d grants %0d want 4 0", s, g); end
    do_cmd(2'b00, 12'h340, 32'h0, 4, rd, er, lat, g, s);
    vectors++; if ({er, rd} !== {2'b00, 32'h1234_567E} || lat != 6) begin miscompares++; $display("FAIL last_wait_access: got %b/%h lat %0d want 00/1234567e lat 6", er, rd, lat); end
    vectors++; if (s != 5 || g != 1) begin miscompares++; $display("FAIL last_wait_counts: stalls %0d grants %0d want 5 1", s, g); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic [1:0] er; int lat, g, s, c0;
    c0 = cyc;
    do_cmd(2'b00, 12'h340, 32'h0, 1, rd, er, lat, g, s);
    vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready: got %b want 1", req_ready); end
    do_cmd(2'b10, 12'h340, 32'h0000_0100, 1, rd, er, lat, g, s);
    vectors++; if (cyc - c0 != 8) begin miscompares++; $display("FAIL b2b_spacing: got %0d cycles want 8", cyc - c0); end
    vectors++; if ({er, rd, mscratch} !== {2'b00, 32'h1234_567E, 32'h1234_577E}) begin miscompares++; $display("FAIL b2b_data: got %b/%h/%h want 00/1234567e/1234577e", er, rd, mscratch); end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] rd; logic [1:0] er; int lat, g, s, seen;
    req_op = 2'b00; req_addr = 12'h340; req_wdata = 32'h0; req_valid = 1'b1; pipe_stalled = 1'b0;
    step();
    req_valid = 1'b0;
    vectors++; if (host_stall_req !== 1'b1) begin miscompares++; $display("FAIL rst_wait_entry: stall %b want 1", host_stall_req); end
    #1 nRST = 1'b0;
    #1;
    vectors++; if ({req_ready, host_stall_req, rsp_valid} !== 3'b100) begin miscompares++; $display("FAIL rst_wait_outputs: ready/stall/valid %b want 100", {req_ready, host_stall_req, rsp_valid}); end
    #2 nRST = 1'b1;
    pipe_stalled = 1'b1; seen = 0;
    for (int i = 0; i < 4; i++) begin step(); if (rsp_valid !== 1'b0 || host_stall_req !== 1'b0) seen++; end
    vectors++; if (seen != 0) begin miscompares++; $display("FAIL rst_wait_dropped: %0d active cycles want 0", seen); end
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step(); step();
    vectors++; if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h1234_577E}) begin miscompares++; $display("FAIL rst_resp_setup: got %b/%h want 1/1234577e", rsp_valid, rsp_rdata); end
    pipe_stalled = 1'b0;
    #2 nRST = 1'b0;
    #1;
    vectors++; if ({rsp_valid, rsp_err, rsp_rdata, req_ready} !== {1'b0, 2'b00, 32'h0, 1'b1}) begin miscompares++; $display("FAIL rst_resp_outputs: got %b/%b/%h/%b want 0/00/0/1", rsp_valid, rsp_err, rsp_rdata, req_ready); end
    #2 nRST = 1'b1;
    seen = 0;
    for (int i = 0; i < 3; i++) begin step(); if (rsp_valid !== 1'b0) seen++; end
    vectors++; if (seen != 0) begin miscompares++; $display("FAIL rst_resp_dropped: %0d valid cycles want 0", seen); end
    do_cmd(2'b11, 12'h340, 32'h0000_0100, 1, rd, er, lat, g, s);
    vectors++; if ({er, rd, mscratch} !== {2'b00, 32'h1234_577E, 32'h1234_567E} || lat != 3) begin miscompares++; $display("FAIL rst_recover: got %b/%h/%h lat %0d want 00/1234577e/1234567e lat 3", er, rd, mscratch, lat); end
  endtask

  initial begin
    req_valid = 1'b0; req_op = 2'b00; req_addr = 12'h000; req_wdata = 32'h0;
    rsp_ready = 1'b0; pipe_stalled = 1'b0;
    test_reset();
    test_read();
    test_rmw();
    test_invalid();
    test_readonly();
    test_timeout();
    test_back_to_back();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/priv_1_7_csr_host_master.md
# priv_1_7_csr_host_master

External-host initiator for the machine-mode CSR register file. Accepts single CSR read/swap/set/clear commands from a host link over a valid/ready handshake. Freezes the pipeline, then drives the CSR file's shared access port for exactly one cycle and returns the read data and an error code. It sits beside the pipeline's CSR port; `host_grant` steers the port mux.

## Interface
Parameters:
- `MAX_WAIT`, 16: WAIT cycles without `pipe_stalled` before the command times out; legal range 1..255.

Ports:
- `CLK` in 1: clock.
- `nRST` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: host command valid.
- `req_ready` out 1: command accepted when high together with `req_valid`.
- `req_op` in 2: 00 read, 01 swap, 10 set, 11 clear.
- `req_addr` in 12: CSR address.
- `req_wdata` in 32: write/mask data.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: host accepts the response.
- `rsp_rdata` out 32: old CSR value.
- `rsp_err` out 2: 00 ok, 01 invalid CSR, 10 timeout, 11 write to read-only.
- `host_stall_req` out 1: request to freeze the pipeline.
- `pipe_stalled` in 1: pipeline frozen; no pipeline CSR op is issued in this cycle or in any following cycle while `host_stall_req` stays high.
- `host_grant` out 1: host owns the CSR port.
- `csr_addr` out 12: driven to the CSR file address.
- `csr_swap`, `csr_set`, `csr_clr` out 1 each: op strobes.
- `csr_wdata` out 32: CSR write data.
- `csr_rdata` in 32: CSR file read data (combinational).
- `csr_invalid` in 1: CSR file invalid-address flag, valid only when an op strobe is high.

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - `req_ready`=1.
  - On handshake, latch op, addr and wdata.
  - If `req_addr[11:10]`==2'b11 and op!=read, go to RESP with err 11. No stall is requested and the port is never touched.
  - Otherwise go to WAIT and clear `wait_cnt`.
- WAIT:
  - `host_stall_req`=1.
  - If `pipe_stalled`=1, go to ACCESS. This takes priority over timeout.
  - Else if `wait_cnt`==MAX_WAIT-1, go to RESP with err 10 and `rsp_rdata`=0.
  - Otherwise increment `wait_cnt` by 1. The counter is 8 bits and saturates; it never wraps.
- ACCESS (exactly one cycle):
  - `host_stall_req`=1, `host_grant`=1, `csr_addr`=latched addr.
  - swap: `csr_swap`=1, `csr_wdata`=latched wdata.
  - set: `csr_set`=1, `csr_wdata`=latched wdata.
  - clear: `csr_clr`=1, `csr_wdata`=latched wdata.
  - read: `csr_set`=1, `csr_wdata`=0. This forces an op strobe so `csr_invalid` is evaluated, and leaves the CSR unmodified.
  - Register `rsp_rdata`<=`csr_rdata`.
  - Register `rsp_err`<=`csr_invalid` ? 01 : 00. On 01, `rsp_rdata` is 0.
  - Go to RESP.
- RESP:
  - `rsp_valid`=1; `rsp_rdata`/`rsp_err` held stable.
  - `host_stall_req`=0, `req_ready`=0.
  - On `rsp_ready`, go to IDLE.
- Outside ACCESS: `host_grant`, all op strobes, `csr_addr` and `csr_wdata` are 0.
- Only one command is outstanding at a time; `req_ready` is high only in IDLE.

## Timing
- Reset (async, any state): FSM to IDLE.
  - Outputs: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=00, `host_stall_req`=0, `host_grant`=0, strobes 0, `csr_addr`=0, `csr_wdata`=0, `wait_cnt`=0.
  - A command in flight is dropped with no response. An ACCESS cut off by reset still leaves whatever the CSR file committed.
- Handshake accepted at cycle T:
  - T+1: WAIT.
  - If `pipe_stalled` is high at T+1: ACCESS at T+2, `rsp_valid` at T+3. Minimum latency is 3 cycles.
- Read-only reject: `rsp_valid` at T+1.
- Timeout: `rsp_valid` at T+1+MAX_WAIT, after MAX_WAIT WAIT cycles with `pipe_stalled` low.
- `pipe_stalled` rising on the last WAIT cycle (`wait_cnt`==MAX_WAIT-1): ACCESS, not timeout.
- `rsp_ready` high on the first RESP cycle: RESP lasts 1 cycle. `req_ready` returns the next cycle; back-to-back commands are spaced at 4 cycles minimum.
- `host_stall_req` falls on the cycle RESP is entered (registered output).

## Test plan
- Read of MSCRATCH holding 0xDEADBEEF, `pipe_stalled` tied 1 → ACCESS one cycle after WAIT with `csr_set`=1, `csr_wdata`=0; `rsp_valid` 3 cycles after accept; rdata 0xDEADBEEF, err 00; MSCRATCH unchanged.
- Swap of 0x12345678 into MSCRATCH, then a set with 0x0000000F, then a clear with 0x00000001 → rdata returned is 0xDEADBEEF, then 0x12345678, then 0x1234567F; final MSCRATCH=0x1234567E.
- Read of unmapped address 0x7FF → err 01, rdata 0, exactly one ACCESS cycle.
- Swap to 0xF10 (read-only) → err 11 at T+1; `host_stall_req` and `host_grant` never high.
- MAX_WAIT=4, `pipe_stalled` held 0 → err 10 at T+5, `host_stall_req` high for 4 cycles. Repeat with `pipe_stalled` rising on the 4th WAIT cycle → ACCESS, err 00.
- Assert `nRST` during WAIT, and separately during RESP with `rsp_ready`=0 → all outputs return to their reset values immediately; no response is produced; the next command completes normally.
